// File: rtl/uart_tx_word_sequencer_pkg.sv
// Shared definitions for the UART word sequencer: state encoding, select width
// and the byte-index helpers that order bytes LSB-first or MSB-first.
package uart_tx_word_sequencer_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic [SEL_W-1:0] first_index(input int nbytes, input bit msb_first);
    logic [SEL_W-1:0] idx;
    idx = msb_first ? SEL_W'(nbytes - 1) : '0;
    return idx;
  endfunction

  function automatic logic [SEL_W-1:0] next_index(input logic [SEL_W-1:0] cur, input bit msb_first);
    logic [SEL_W-1:0] idx;
    idx = msb_first ? (cur - SEL_W'(1)) : (cur + SEL_W'(1));
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_word_sequencer.sv
// Steps a latched 32-bit word through the TX byte mux one byte at a time,
// handshaking each byte with the UART transmitter.
module uart_tx_word_sequencer
  import uart_tx_word_sequencer_pkg::*;
#(
  parameter int NBYTES     = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic [SEL_W-1:0] sel,
  output logic             load_en,
  output logic             tx_start,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             last_byte;

  assign last_byte = (cnt_q == SEL_W'(NBYTES - 1));
  assign sel       = sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decode from state so an async reset clears them in the same cycle.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    load_en  = 1'b0;
    tx_start = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
          sel_d   = first_index(NBYTES, MSB_FIRST);
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The terminal compare comes first, so the byte counter never wraps.
        if (tx_done) begin
          if (last_byte) begin
            state_d = ST_DONE;
          end else begin
            sel_d = next_index(sel_q, MSB_FIRST);
            cnt_d = cnt_q + SEL_W'(1);
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = 8'(GAP_CYCLES);
            end else begin
              state_d = ST_SEND;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd1) begin
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
// Scoreboard bench: four sequencer configurations, each with its own word
// register, byte mux and 10-cycle UART TX model.
module tb_uart_tx_word_sequencer;

  localparam int BYTE_TIME = 10;

  typedef struct packed {
    logic [1:0] inst;
    logic       first;
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  function automatic int cfg_nbytes(input int g);
    case (g)
      1:       return 2;
      3:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit cfg_msb_first(input int g);
    return (g == 1);
  endfunction

  function automatic int cfg_gap(input int g);
    return (g == 2) ? 3 : 0;
  endfunction

  logic        clk;
  logic        rst;
  int          cyc;
  logic        start_a  [4];
  logic        hold_a   [4];
  logic        spur_a   [4];
  logic [31:0] word_a   [4];
  logic [1:0]  sel_a    [4];
  logic        load_a   [4];
  logic        txs_a    [4];
  logic        busy_a   [4];
  logic        done_a   [4];
  logic        txbusy_a [4];
  logic        txdone_a [4];

  exp_t exp_q[$];
  int   num_vectors = 0;
  int   num_miscompares = 0;
  int   words_done = 0;
  int   exp_words = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic scoreTxStart(input int g, input logic txs, input logic [1:0] s, input logic [7:0] b,
                              input int delta, input int gap);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("extra_tx_start", 32'(txs), 32'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("inst_sel_byte", {20'd0, 2'(g), s, b}, {20'd0, e.inst, e.sel, e.data});
      if (!e.first) checkOutput("tx_start_spacing", 32'(delta), 32'(gap + 1));
    end
  endtask

  task automatic noteDone(input int delta);
    checkOutput("done_latency", 32'(delta), 32'd1);
    checkOutput("bytes_left_at_done", 32'(exp_q.size()), 32'd0);
    words_done++;
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int NB = cfg_nbytes(g);
    localparam bit MF = cfg_msb_first(g);
    localparam int GP = cfg_gap(g);

    logic [31:0] word_reg = '0;
    logic [7:0]  mux_byte;
    int          bit_cnt = 0;
    logic        model_done = 1'b0;
    int          last_done_cyc = 0;
    logic        prev_done = 1'b0;

    uart_tx_word_sequencer #(
      .NBYTES    (NB),
      .MSB_FIRST (MF),
      .GAP_CYCLES(GP)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a[g]),
      .tx_busy (txbusy_a[g]),
      .tx_done (txdone_a[g]),
      .sel     (sel_a[g]),
      .load_en (load_a[g]),
      .tx_start(txs_a[g]),
      .busy    (busy_a[g]),
      .done    (done_a[g])
    );

    assign mux_byte    = word_reg[{sel_a[g], 3'b000} +: 8];
    assign txbusy_a[g] = (bit_cnt != 0) || hold_a[g];
    assign txdone_a[g] = model_done || spur_a[g];

    // Word register, plus a TX core that is busy for BYTE_TIME cycles per byte.
    always @(posedge clk) begin
      if (load_a[g]) word_reg <= word_a[g];
      model_done <= 1'b0;
      if (txs_a[g]) begin
        bit_cnt <= BYTE_TIME;
      end else if (bit_cnt != 0) begin
        bit_cnt <= bit_cnt - 1;
        if (bit_cnt == 1) model_done <= 1'b1;
      end
    end

    always @(negedge clk) begin
      if (txs_a[g]) scoreTxStart(g, txs_a[g], sel_a[g], mux_byte, cyc - last_done_cyc, GP);
      if (done_a[g]) noteDone(cyc - last_done_cyc);
      if (prev_done) checkOutput("busy_after_done", 32'(busy_a[g]), 32'd0);
      prev_done <= done_a[g];
      if (model_done) last_done_cyc <= cyc;
    end
  end

  task automatic applyStimulus(input int g, input logic [31:0] word);
    exp_t e;
    int   nb;
    int   idx;
    nb = cfg_nbytes(g);
    for (int i = 0; i < nb; i++) begin
      idx     = cfg_msb_first(g) ? (nb - 1 - i) : i;
      e.inst  = 2'(g);
      e.first = (i == 0);
      e.sel   = 2'(idx);
      e.data  = word[8*idx +: 8];
      exp_q.push_back(e);
    end
    word_a[g]  = word;
    start_a[g] = 1'b1;
    @(posedge clk); #1;
    start_a[g] = 1'b0;
    checkOutput("load_en_on_accept", 32'(load_a[g]), 32'd1);
    checkOutput("busy_on_accept", 32'(busy_a[g]), 32'd1);
  endtask

  task automatic waitDone(input int g, input int limit);
    int n;
    n = 0;
    exp_words++;
    while (!done_a[g] && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done_a[g]) checkOutput("done_timeout", 32'(done_a[g]), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic checkIdleOutputs(input int g, input string tag);
    checkOutput({tag, "_sel"}, 32'(sel_a[g]), 32'd0);
    checkOutput({tag, "_load_en"}, 32'(load_a[g]), 32'd0);
    checkOutput({tag, "_tx_start"}, 32'(txs_a[g]), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_a[g]), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_a[g]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0;
      hold_a[i]  = 1'b0;
      spur_a[i]  = 1'b0;
      word_a[i]  = '0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs(0, "reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Default word: bytes D4,C3,B2,A1 with sel 0..3.
    applyStimulus(0, 32'hA1B2C3D4);
    @(posedge clk); #1;
    checkOutput("load_en_single_cycle", 32'(load_a[0]), 32'd0);
    checkOutput("tx_start_latency", 32'(txs_a[0]), 32'd1);
    waitDone(0, 300);

    // TX busy holds the first byte in SEND; a spurious tx_done there is ignored.
    hold_a[0] = 1'b1;
    applyStimulus(0, 32'h11223344);
    for (int i = 0; i < 6; i++) begin
      spur_a[0] = (i == 3);
      checkOutput("tx_start_held", 32'(txs_a[0]), 32'd0);
      @(posedge clk); #1;
    end
    hold_a[0] = 1'b0;
    spur_a[0] = 1'b1;
    #1;
    checkOutput("tx_start_on_release", 32'(txs_a[0]), 32'd1);
    @(posedge clk); #1;
    spur_a[0] = 1'b0;
    waitDone(0, 300);

    // Reset while the second byte is in flight.
    applyStimulus(0, 32'hCAFEF00D);
    repeat (14) @(posedge clk);
    #1;
    checkOutput("sel_mid_word", 32'(sel_a[0]), 32'd1);
    rst = 1'b0;
    #1;
    checkIdleOutputs(0, "abort");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_after_abort", 32'(busy_a[0]), 32'd0);
    applyStimulus(0, 32'h0BADCAFE);
    waitDone(0, 300);

    // MSB-first, two bytes, second word started the cycle busy drops.
    applyStimulus(1, 32'h55667788);
    waitDone(1, 300);
    applyStimulus(1, 32'h9A9B9C9D);
    waitDone(1, 300);

    // Three-cycle gap; spurious tx_done in GAP and starts while busy are ignored.
    applyStimulus(2, 32'hDEADBEEF);
    repeat (14) @(posedge clk);
    #1;
    spur_a[2] = 1'b1;
    @(posedge clk); #1;
    spur_a[2]  = 1'b0;
    start_a[2] = 1'b1;
    @(posedge clk); #1;
    start_a[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start_a[2] = 1'b1;
    @(posedge clk); #1;
    start_a[2] = 1'b0;
    waitDone(2, 400);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_queued_word", 32'(busy_a[2]), 32'd0);

    // Single-byte word after a spurious tx_done in IDLE.
    spur_a[3] = 1'b1;
    @(posedge clk); #1;
    spur_a[3] = 1'b0;
    checkOutput("spur_idle_busy", 32'(busy_a[3]), 32'd0);
    checkOutput("spur_idle_load_en", 32'(load_a[3]), 32'd0);
    applyStimulus(3, 32'h123456A5);
    waitDone(3, 300);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("words_done", 32'(words_done), 32'(exp_words));
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
